// File: rtl/aurora_seq_pkg.sv
`default_nettype none
// Shared types and helpers for the Aurora sequence framer.
// Revision: 1.0
package aurora_seq_pkg;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_PASS = 2'd1,
      TX_SEQ  = 2'd2
   } tx_state_e;

   // The caller truncates the result back to its own counter width.
   function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input int width);
      logic [63:0] max_v;
      max_v = (64'd1 << width) - 64'd1;
      return (cnt >= max_v) ? max_v : cnt + 64'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aurora_seq_rx_strip.sv
`default_nettype none
// RX side: one-word hold, trailing sequence-word strip, continuity check and RX statistics.
// Revision: 1.0
module aurora_seq_rx_strip
   import aurora_seq_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int SEQ_W  = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              s_tvalid_i,
   input  logic [DATA_W-1:0] s_tdata_i,
   input  logic              s_tlast_i,
   input  logic              strip_en_i,
   input  logic              clear_i,
   output logic              m_tvalid_o,
   output logic [DATA_W-1:0] m_tdata_o,
   output logic              m_tlast_o,
   output logic [SEQ_W-1:0]  seq_last_o,
   output logic [CNT_W-1:0]  frame_cnt_o,
   output logic [CNT_W-1:0]  seq_err_cnt_o,
   output logic [CNT_W-1:0]  runt_cnt_o
);

   logic [DATA_W-1:0] hold_data_q, hold_data_d;
   logic              hold_vld_q, hold_vld_d;
   logic              in_frame_q, in_frame_d;
   logic              strip_q, strip_d;
   logic              first_q, first_d;
   logic [SEQ_W-1:0]  seq_last_q, seq_last_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]  runt_cnt_q, runt_cnt_d;
   logic              out_vld_q, out_vld_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic              w_strip;
   logic [SEQ_W-1:0]  w_seq;
   logic [SEQ_W-1:0]  w_seq_exp;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_data_q <= '0;
         hold_vld_q  <= 1'b0;
         in_frame_q  <= 1'b0;
         strip_q     <= 1'b0;
         first_q     <= 1'b1;
         seq_last_q  <= '0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
         runt_cnt_q  <= '0;
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         hold_data_q <= hold_data_d;
         hold_vld_q  <= hold_vld_d;
         in_frame_q  <= in_frame_d;
         strip_q     <= strip_d;
         first_q     <= first_d;
         seq_last_q  <= seq_last_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
         runt_cnt_q  <= runt_cnt_d;
         out_vld_q   <= out_vld_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   // Strip mode is frozen on the first beat of a frame so a mid-frame toggle is ignored.
   assign w_strip   = in_frame_q ? strip_q : strip_en_i;
   assign w_seq     = s_tdata_i[SEQ_W-1:0];
   assign w_seq_exp = seq_last_q + SEQ_W'(1);

   always_comb begin
      hold_data_d = hold_data_q;
      hold_vld_d  = hold_vld_q;
      in_frame_d  = in_frame_q;
      strip_d     = strip_q;
      first_d     = first_q;
      seq_last_d  = seq_last_q;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      runt_cnt_d  = runt_cnt_q;
      out_vld_d   = 1'b0;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (s_tvalid_i) begin
         in_frame_d = ~s_tlast_i;
         strip_d    = w_strip;
         if (!w_strip) begin
            out_vld_d  = 1'b1;
            out_data_d = s_tdata_i;
            out_last_d = s_tlast_i;
            if (s_tlast_i) begin
               frame_cnt_d = CNT_W'(sat_inc(64'(frame_cnt_q), CNT_W));
            end
         end else if (!s_tlast_i) begin
            if (hold_vld_q) begin
               out_vld_d  = 1'b1;
               out_data_d = hold_data_q;
               out_last_d = 1'b0;
            end
            hold_data_d = s_tdata_i;
            hold_vld_d  = 1'b1;
         end else if (hold_vld_q) begin
            out_vld_d  = 1'b1;
            out_data_d = hold_data_q;
            out_last_d = 1'b1;
            hold_vld_d = 1'b0;
            if (!first_q && (w_seq != w_seq_exp)) begin
               err_cnt_d = CNT_W'(sat_inc(64'(err_cnt_q), CNT_W));
            end
            first_d     = 1'b0;
            seq_last_d  = w_seq;
            frame_cnt_d = CNT_W'(sat_inc(64'(frame_cnt_q), CNT_W));
         end else begin
            // A frame holding only the sequence word carries no payload.
            runt_cnt_d = CNT_W'(sat_inc(64'(runt_cnt_q), CNT_W));
         end
      end
      if (clear_i) begin
         first_d     = 1'b1;
         seq_last_d  = '0;
         frame_cnt_d = '0;
         err_cnt_d   = '0;
         runt_cnt_d  = '0;
      end
   end

   assign m_tvalid_o    = out_vld_q;
   assign m_tdata_o     = out_data_q;
   assign m_tlast_o     = out_last_q;
   assign seq_last_o    = seq_last_q;
   assign frame_cnt_o   = frame_cnt_q;
   assign seq_err_cnt_o = err_cnt_q;
   assign runt_cnt_o    = runt_cnt_q;

endmodule
`default_nettype wire

// File: rtl/aurora_seq_framer.sv
`default_nettype none
// Sequence-number framer around the Aurora user interface: TX trailer append FSM plus RX strip/check.
// Revision: 1.0
module aurora_seq_framer
   import aurora_seq_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int SEQ_W  = 32,
   parameter int CNT_W  = 16
) (
   input  logic              m_axis_aclk,
   input  logic              m_axis_aresetn,
   input  logic              s_axis_tx_tvalid,
   input  logic [DATA_W-1:0] s_axis_tx_tdata,
   input  logic              s_axis_tx_tlast,
   output logic              s_axis_tx_tready,
   output logic              m_axis_tx_tvalid,
   output logic [DATA_W-1:0] m_axis_tx_tdata,
   output logic              m_axis_tx_tlast,
   input  logic              m_axis_tx_tready,
   input  logic              s_axis_rx_tvalid,
   input  logic [DATA_W-1:0] s_axis_rx_tdata,
   input  logic              s_axis_rx_tlast,
   output logic              m_axis_rx_tvalid,
   output logic [DATA_W-1:0] m_axis_rx_tdata,
   output logic              m_axis_rx_tlast,
   input  logic              ctrl_append_seq_en,
   input  logic              ctrl_strip_seq_en,
   input  logic              ctrl_clear,
   output logic [SEQ_W-1:0]  tx_seq,
   output logic [SEQ_W-1:0]  rx_seq_last,
   output logic [CNT_W-1:0]  rx_frame_cnt,
   output logic [CNT_W-1:0]  tx_frame_cnt,
   output logic [CNT_W-1:0]  rx_seq_err_cnt,
   output logic [CNT_W-1:0]  rx_runt_cnt
);

   tx_state_e        state_q, state_d;
   logic             mode_q, mode_d;
   logic [SEQ_W-1:0] tx_seq_q, tx_seq_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         state_q  <= TX_IDLE;
         mode_q   <= 1'b0;
         tx_seq_q <= '0;
         tx_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         tx_seq_q <= tx_seq_d;
         tx_cnt_q <= tx_cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      tx_seq_d = tx_seq_q;
      tx_cnt_d = tx_cnt_q;
      case (state_q)
         TX_IDLE: begin
            if (s_axis_tx_tvalid && m_axis_tx_tready) begin
               mode_d = ctrl_append_seq_en;
               if (!s_axis_tx_tlast) begin
                  state_d = TX_PASS;
               end else if (ctrl_append_seq_en) begin
                  state_d = TX_SEQ;
               end else begin
                  tx_cnt_d = CNT_W'(sat_inc(64'(tx_cnt_q), CNT_W));
               end
            end
         end
         TX_PASS: begin
            if (s_axis_tx_tvalid && m_axis_tx_tready && s_axis_tx_tlast) begin
               if (mode_q) begin
                  state_d = TX_SEQ;
               end else begin
                  tx_cnt_d = CNT_W'(sat_inc(64'(tx_cnt_q), CNT_W));
                  state_d  = TX_IDLE;
               end
            end
         end
         TX_SEQ: begin
            if (m_axis_tx_tready) begin
               tx_seq_d = tx_seq_q + SEQ_W'(1);
               tx_cnt_d = CNT_W'(sat_inc(64'(tx_cnt_q), CNT_W));
               state_d  = TX_IDLE;
            end
         end
         default: state_d = TX_IDLE;
      endcase
      if (ctrl_clear) begin
         tx_seq_d = '0;
         tx_cnt_d = '0;
      end
   end

   // Passthrough is combinational, so the reset gate keeps the TX outputs low while reset is held.
   always_comb begin
      s_axis_tx_tready = 1'b0;
      m_axis_tx_tvalid = 1'b0;
      m_axis_tx_tdata  = '0;
      m_axis_tx_tlast  = 1'b0;
      if (m_axis_aresetn) begin
         case (state_q)
            TX_IDLE: begin
               s_axis_tx_tready = m_axis_tx_tready;
               m_axis_tx_tvalid = s_axis_tx_tvalid;
               m_axis_tx_tdata  = s_axis_tx_tdata;
               m_axis_tx_tlast  = s_axis_tx_tlast & ~ctrl_append_seq_en;
            end
            TX_PASS: begin
               s_axis_tx_tready = m_axis_tx_tready;
               m_axis_tx_tvalid = s_axis_tx_tvalid;
               m_axis_tx_tdata  = s_axis_tx_tdata;
               m_axis_tx_tlast  = s_axis_tx_tlast & ~mode_q;
            end
            TX_SEQ: begin
               m_axis_tx_tvalid = 1'b1;
               m_axis_tx_tdata  = DATA_W'(tx_seq_q);
               m_axis_tx_tlast  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign tx_seq       = tx_seq_q;
   assign tx_frame_cnt = tx_cnt_q;

   aurora_seq_rx_strip #(
      .DATA_W (DATA_W),
      .SEQ_W  (SEQ_W),
      .CNT_W  (CNT_W)
   ) u_rx_strip (
      .clk_i         (m_axis_aclk),
      .rst_ni        (m_axis_aresetn),
      .s_tvalid_i    (s_axis_rx_tvalid),
      .s_tdata_i     (s_axis_rx_tdata),
      .s_tlast_i     (s_axis_rx_tlast),
      .strip_en_i    (ctrl_strip_seq_en),
      .clear_i       (ctrl_clear),
      .m_tvalid_o    (m_axis_rx_tvalid),
      .m_tdata_o     (m_axis_rx_tdata),
      .m_tlast_o     (m_axis_rx_tlast),
      .seq_last_o    (rx_seq_last),
      .frame_cnt_o   (rx_frame_cnt),
      .seq_err_cnt_o (rx_seq_err_cnt),
      .runt_cnt_o    (rx_runt_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_aurora_seq_framer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for aurora_seq_framer: default instance for TX/RX directed frames, plus an
// 8-bit sequence / 4-bit counter instance with TX looped back into RX for wrap-around.
module tb_aurora_seq_framer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        s_axis_tx_tvalid, s_axis_tx_tlast, s_axis_tx_tready;
   logic [31:0] s_axis_tx_tdata;
   logic        m_axis_tx_tvalid, m_axis_tx_tlast, m_axis_tx_tready;
   logic [31:0] m_axis_tx_tdata;
   logic        s_axis_rx_tvalid, s_axis_rx_tlast;
   logic [31:0] s_axis_rx_tdata;
   logic        m_axis_rx_tvalid, m_axis_rx_tlast;
   logic [31:0] m_axis_rx_tdata;
   logic        ctrl_append_seq_en, ctrl_strip_seq_en, ctrl_clear;
   logic [31:0] tx_seq, rx_seq_last;
   logic [15:0] rx_frame_cnt, tx_frame_cnt, rx_seq_err_cnt, rx_runt_cnt;

   logic        w2_s_tx_tvalid, w2_s_tx_tlast, w2_s_tx_tready;
   logic [31:0] w2_s_tx_tdata;
   logic        w2_m_tx_tvalid, w2_m_tx_tlast, w2_m_tx_tready;
   logic [31:0] w2_m_tx_tdata;
   wire         w2_s_rx_tvalid, w2_s_rx_tlast;
   wire  [31:0] w2_s_rx_tdata;
   logic        w2_m_rx_tvalid, w2_m_rx_tlast;
   logic [31:0] w2_m_rx_tdata;
   logic        w2_append, w2_strip, w2_clear;
   logic [7:0]  w2_tx_seq, w2_rx_seq_last;
   logic [3:0]  w2_rx_frame_cnt, w2_tx_frame_cnt, w2_rx_seq_err_cnt, w2_rx_runt_cnt;

   assign w2_s_rx_tvalid = w2_m_tx_tvalid & w2_m_tx_tready;
   assign w2_s_rx_tdata  = w2_m_tx_tdata;
   assign w2_s_rx_tlast  = w2_m_tx_tlast;

   aurora_seq_framer #(.DATA_W(32), .SEQ_W(32), .CNT_W(16)) u_dut (
      .m_axis_aclk(clk), .m_axis_aresetn(rst_n),
      .s_axis_tx_tvalid(s_axis_tx_tvalid), .s_axis_tx_tdata(s_axis_tx_tdata),
      .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tready(s_axis_tx_tready),
      .m_axis_tx_tvalid(m_axis_tx_tvalid), .m_axis_tx_tdata(m_axis_tx_tdata),
      .m_axis_tx_tlast(m_axis_tx_tlast), .m_axis_tx_tready(m_axis_tx_tready),
      .s_axis_rx_tvalid(s_axis_rx_tvalid), .s_axis_rx_tdata(s_axis_rx_tdata),
      .s_axis_rx_tlast(s_axis_rx_tlast),
      .m_axis_rx_tvalid(m_axis_rx_tvalid), .m_axis_rx_tdata(m_axis_rx_tdata),
      .m_axis_rx_tlast(m_axis_rx_tlast),
      .ctrl_append_seq_en(ctrl_append_seq_en), .ctrl_strip_seq_en(ctrl_strip_seq_en),
      .ctrl_clear(ctrl_clear),
      .tx_seq(tx_seq), .rx_seq_last(rx_seq_last),
      .rx_frame_cnt(rx_frame_cnt), .tx_frame_cnt(tx_frame_cnt),
      .rx_seq_err_cnt(rx_seq_err_cnt), .rx_runt_cnt(rx_runt_cnt)
   );

   aurora_seq_framer #(.DATA_W(32), .SEQ_W(8), .CNT_W(4)) u_wrap (
      .m_axis_aclk(clk), .m_axis_aresetn(rst_n),
      .s_axis_tx_tvalid(w2_s_tx_tvalid), .s_axis_tx_tdata(w2_s_tx_tdata),
      .s_axis_tx_tlast(w2_s_tx_tlast), .s_axis_tx_tready(w2_s_tx_tready),
      .m_axis_tx_tvalid(w2_m_tx_tvalid), .m_axis_tx_tdata(w2_m_tx_tdata),
      .m_axis_tx_tlast(w2_m_tx_tlast), .m_axis_tx_tready(w2_m_tx_tready),
      .s_axis_rx_tvalid(w2_s_rx_tvalid), .s_axis_rx_tdata(w2_s_rx_tdata),
      .s_axis_rx_tlast(w2_s_rx_tlast),
      .m_axis_rx_tvalid(w2_m_rx_tvalid), .m_axis_rx_tdata(w2_m_rx_tdata),
      .m_axis_rx_tlast(w2_m_rx_tlast),
      .ctrl_append_seq_en(w2_append), .ctrl_strip_seq_en(w2_strip), .ctrl_clear(w2_clear),
      .tx_seq(w2_tx_seq), .rx_seq_last(w2_rx_seq_last),
      .rx_frame_cnt(w2_rx_frame_cnt), .tx_frame_cnt(w2_tx_frame_cnt),
      .rx_seq_err_cnt(w2_rx_seq_err_cnt), .rx_runt_cnt(w2_rx_runt_cnt)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   beat_t       tx_q[$];
   beat_t       rx_q[$];
   beat_t       wrap_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_tx_seq = 32'd0;
   logic [7:0]  wrap_seq   = 8'd0;
   int          wrap_trailers = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitors: pop one expected beat per accepted/produced output beat.
   always @(negedge clk) begin : mon_tx
      beat_t e;
      if (rst_n && m_axis_tx_tvalid && m_axis_tx_tready) begin
         if (tx_q.size() == 0) begin
            check_eq("tx_unexpected_beat", {32'd0, m_axis_tx_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = tx_q.pop_front();
            check_eq("tx_tdata", m_axis_tx_tdata, e.data);
            check_eq("tx_tlast", m_axis_tx_tlast, e.last);
         end
      end
   end

   always @(negedge clk) begin : mon_rx
      beat_t e;
      if (rst_n && m_axis_rx_tvalid) begin
         if (rx_q.size() == 0) begin
            check_eq("rx_unexpected_beat", {32'd0, m_axis_rx_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = rx_q.pop_front();
            check_eq("rx_tdata", m_axis_rx_tdata, e.data);
            check_eq("rx_tlast", m_axis_rx_tlast, e.last);
         end
      end
   end

   always @(negedge clk) begin : mon_wrap
      beat_t e;
      if (rst_n && w2_m_tx_tvalid && w2_m_tx_tready && w2_m_tx_tlast) begin
         check_eq("wrap_trailer", w2_m_tx_tdata, {24'd0, wrap_seq});
         wrap_seq = wrap_seq + 8'd1;
         wrap_trailers++;
      end
      if (rst_n && w2_m_rx_tvalid) begin
         if (wrap_q.size() == 0) begin
            check_eq("wrap_unexpected_beat", {32'd0, w2_m_rx_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = wrap_q.pop_front();
            check_eq("wrap_rx_tdata", w2_m_rx_tdata, e.data);
            check_eq("wrap_rx_tlast", w2_m_rx_tlast, e.last);
         end
      end
   end

   task automatic tx_frame(input int n, input logic [31:0] base, input bit append, input bit toggle);
      bit acc;
      int guard;
      ctrl_append_seq_en = append;
      for (int i = 0; i < n; i++) begin
         s_axis_tx_tvalid = 1'b1;
         s_axis_tx_tdata  = base + 32'(i);
         s_axis_tx_tlast  = (i == n - 1);
         tx_q.push_back('{data: base + 32'(i), last: (i == n - 1) && !append});
         acc = 1'b0;
         guard = 0;
         while (!acc) begin
            @(negedge clk);
            acc = s_axis_tx_tready;
            tick();
            if (toggle) m_axis_tx_tready = ~m_axis_tx_tready;
            guard++;
            if (guard > 50) begin
               check_eq("tx_beat_timeout", 1, 0);
               acc = 1'b1;
            end
         end
      end
      s_axis_tx_tvalid = 1'b0;
      s_axis_tx_tlast  = 1'b0;
      if (append) begin
         tx_q.push_back('{data: exp_tx_seq, last: 1'b1});
         acc = 1'b0;
         guard = 0;
         while (!acc) begin
            @(negedge clk);
            check_eq("seq_s_tready_low", s_axis_tx_tready, 0);
            check_eq("seq_tvalid_held", m_axis_tx_tvalid, 1);
            check_eq("seq_tdata_held", m_axis_tx_tdata, exp_tx_seq);
            acc = m_axis_tx_tready;
            tick();
            if (toggle) m_axis_tx_tready = ~m_axis_tx_tready;
            guard++;
            if (guard > 50) begin
               check_eq("tx_trailer_timeout", 1, 0);
               acc = 1'b1;
            end
         end
         exp_tx_seq = exp_tx_seq + 32'd1;
      end
   endtask

   task automatic rx_frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input bit strip);
      logic [31:0] w [3];
      w[0] = w0;
      w[1] = w1;
      w[2] = w2;
      ctrl_strip_seq_en = strip;
      for (int i = 0; i < n; i++) begin
         s_axis_rx_tvalid = 1'b1;
         s_axis_rx_tdata  = w[i];
         s_axis_rx_tlast  = (i == n - 1);
         if (!strip) rx_q.push_back('{data: w[i], last: (i == n - 1)});
         else if (i < n - 1) rx_q.push_back('{data: w[i], last: (i == n - 2)});
         tick();
      end
      s_axis_rx_tvalid = 1'b0;
      s_axis_rx_tlast  = 1'b0;
   endtask

   task automatic run_wrap();
      bit acc;
      int guard;
      for (int k = 0; k < 257; k++) begin
         w2_s_tx_tvalid = 1'b1;
         w2_s_tx_tdata  = 32'hA500_0000 + 32'(k);
         w2_s_tx_tlast  = 1'b1;
         wrap_q.push_back('{data: 32'hA500_0000 + 32'(k), last: 1'b1});
         acc = 1'b0;
         guard = 0;
         while (!acc) begin
            @(negedge clk);
            acc = w2_s_tx_tready;
            tick();
            guard++;
            if (guard > 20) begin
               check_eq("wrap_beat_timeout", 1, 0);
               acc = 1'b1;
            end
         end
      end
      w2_s_tx_tvalid = 1'b0;
      w2_s_tx_tlast  = 1'b0;
      repeat (4) tick();
      check_eq("wrap_trailer_count", wrap_trailers, 257);
      check_eq("wrap_tx_seq", w2_tx_seq, 8'h01);
      check_eq("wrap_rx_seq_last", w2_rx_seq_last, 8'h00);
      check_eq("wrap_rx_err_cnt", w2_rx_seq_err_cnt, 0);
      check_eq("wrap_tx_cnt_sat", w2_tx_frame_cnt, 4'hF);
      check_eq("wrap_rx_cnt_sat", w2_rx_frame_cnt, 4'hF);
      check_eq("wrap_runt_cnt", w2_rx_runt_cnt, 0);
      check_eq("wrap_queue_drained", wrap_q.size(), 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      s_axis_tx_tvalid = 1'b0; s_axis_tx_tdata = '0; s_axis_tx_tlast = 1'b0;
      m_axis_tx_tready = 1'b1;
      s_axis_rx_tvalid = 1'b0; s_axis_rx_tdata = '0; s_axis_rx_tlast = 1'b0;
      ctrl_append_seq_en = 1'b0; ctrl_strip_seq_en = 1'b0; ctrl_clear = 1'b0;
      w2_s_tx_tvalid = 1'b0; w2_s_tx_tdata = '0; w2_s_tx_tlast = 1'b0;
      w2_m_tx_tready = 1'b1; w2_append = 1'b1; w2_strip = 1'b1; w2_clear = 1'b0;

      repeat (3) tick();
      check_eq("rst_m_tx_tvalid", m_axis_tx_tvalid, 0);
      check_eq("rst_s_tx_tready", s_axis_tx_tready, 0);
      check_eq("rst_m_rx_tvalid", m_axis_rx_tvalid, 0);
      check_eq("rst_tx_seq", tx_seq, 0);
      check_eq("rst_tx_frame_cnt", tx_frame_cnt, 0);
      check_eq("rst_rx_seq_last", rx_seq_last, 0);
      rst_n = 1'b1;
      tick();

      // TX append: trailers 0, 1, 2 then a plain frame and a plain single-beat frame.
      tx_frame(3, 32'hA0, 1'b1, 1'b0);
      tx_frame(2, 32'hB0, 1'b1, 1'b0);
      check_eq("tx_frame_cnt_2", tx_frame_cnt, 2);
      check_eq("tx_seq_2", tx_seq, 2);
      tx_frame(3, 32'hC0, 1'b1, 1'b1);
      m_axis_tx_tready = 1'b1;
      check_eq("tx_frame_cnt_3", tx_frame_cnt, 3);
      tx_frame(2, 32'hD0, 1'b0, 1'b0);
      tx_frame(1, 32'hE0, 1'b0, 1'b0);
      tick();
      check_eq("tx_frame_cnt_5", tx_frame_cnt, 5);
      check_eq("tx_seq_3", tx_seq, 3);
      check_eq("tx_queue_drained", tx_q.size(), 0);

      // RX strip: continuity break, runt, then strip disabled.
      rx_frame(3, 32'hD0, 32'hD1, 32'd5, 1'b1);
      rx_frame(2, 32'hE0, 32'd7, 32'd0, 1'b1);
      tick();
      check_eq("rx_err_cnt_1", rx_seq_err_cnt, 1);
      check_eq("rx_seq_last_7", rx_seq_last, 7);
      check_eq("rx_frame_cnt_2", rx_frame_cnt, 2);
      rx_frame(1, 32'd9, 32'd0, 32'd0, 1'b1);
      tick();
      check_eq("rx_runt_cnt_1", rx_runt_cnt, 1);
      check_eq("rx_seq_last_kept", rx_seq_last, 7);
      check_eq("rx_frame_cnt_runt", rx_frame_cnt, 2);
      rx_frame(2, 32'hF0, 32'hF1, 32'd0, 1'b0);
      tick();
      check_eq("rx_frame_cnt_3", rx_frame_cnt, 3);

      // Clear coinciding with an RX frame completion: clear wins, rx_first re-armed.
      ctrl_clear = 1'b1;
      rx_frame(1, 32'h77, 32'd0, 32'd0, 1'b0);
      ctrl_clear = 1'b0;
      tick();
      check_eq("clr_rx_frame_cnt", rx_frame_cnt, 0);
      check_eq("clr_rx_err_cnt", rx_seq_err_cnt, 0);
      check_eq("clr_rx_runt_cnt", rx_runt_cnt, 0);
      check_eq("clr_rx_seq_last", rx_seq_last, 0);
      check_eq("clr_tx_seq", tx_seq, 0);
      check_eq("clr_tx_frame_cnt", tx_frame_cnt, 0);
      exp_tx_seq = 32'd0;
      rx_frame(2, 32'h11, 32'd100, 32'd0, 1'b1);
      tick();
      check_eq("clr_first_no_err", rx_seq_err_cnt, 0);
      check_eq("clr_seq_last_100", rx_seq_last, 100);
      check_eq("rx_queue_drained", rx_q.size(), 0);

      run_wrap();

      // Async reset with TX in SEQ and RX holding a word.
      ctrl_append_seq_en = 1'b1;
      m_axis_tx_tready   = 1'b1;
      s_axis_tx_tvalid = 1'b1; s_axis_tx_tdata = 32'hCAFE; s_axis_tx_tlast = 1'b1;
      tx_q.push_back('{data: 32'hCAFE, last: 1'b0});
      tick();
      s_axis_tx_tvalid = 1'b0; s_axis_tx_tlast = 1'b0;
      m_axis_tx_tready = 1'b0;
      ctrl_strip_seq_en = 1'b1;
      s_axis_rx_tvalid = 1'b1; s_axis_rx_tdata = 32'hBAD0; s_axis_rx_tlast = 1'b0;
      tick();
      s_axis_rx_tvalid = 1'b0;
      @(negedge clk);
      check_eq("pre_rst_seq_valid", m_axis_tx_tvalid, 1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("arst_m_tx_tvalid", m_axis_tx_tvalid, 0);
      check_eq("arst_m_tx_tlast", m_axis_tx_tlast, 0);
      check_eq("arst_m_tx_tdata", m_axis_tx_tdata, 0);
      check_eq("arst_rx_frame_cnt", rx_frame_cnt, 0);
      check_eq("arst_rx_seq_last", rx_seq_last, 0);
      tick();
      rst_n = 1'b1;
      m_axis_tx_tready = 1'b1;
      tick();
      rx_frame(2, 32'hF00D, 32'd55, 32'd0, 1'b1);
      tick();
      check_eq("post_rst_no_err", rx_seq_err_cnt, 0);
      check_eq("post_rst_seq_last", rx_seq_last, 55);
      check_eq("post_rst_frame_cnt", rx_frame_cnt, 1);
      check_eq("final_tx_queue", tx_q.size(), 0);
      check_eq("final_rx_queue", rx_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
